// File: rtl/video_timing_gen_if.sv
// Bundles the pixel enable, the timing configuration and the raster timing
// outputs of video_timing_gen. The generator connects through slave and
// its driver or consumer connects through master.
interface video_timing_gen_if #(
  parameter int X_BITS     = 12,
  parameter int Y_BITS     = 12,
  parameter int FRAME_BITS = 8
);
  logic                  ce_pix;
  logic                  cfg_we;
  logic [X_BITS-1:0]     cfg_h_total;
  logic [X_BITS-1:0]     cfg_h_fp;
  logic [X_BITS-1:0]     cfg_h_bp;
  logic [X_BITS-1:0]     cfg_h_sync;
  logic [X_BITS-1:0]     cfg_hv_offset;
  logic [Y_BITS-1:0]     cfg_v_total;
  logic [Y_BITS-1:0]     cfg_v_fp;
  logic [Y_BITS-1:0]     cfg_v_bp;
  logic [Y_BITS-1:0]     cfg_v_sync;
  logic                  cfg_interlace;
  logic                  cfg_hs_pol;
  logic                  cfg_vs_pol;
  logic                  cfg_pending;
  logic                  hs;
  logic                  vs;
  logic                  hde;
  logic                  vde;
  logic                  de;
  logic                  field;
  logic                  sof;
  logic [X_BITS-1:0]     h_count;
  logic [Y_BITS-1:0]     v_count;
  logic [X_BITS-1:0]     x;
  logic [Y_BITS-1:0]     y;
  logic [FRAME_BITS-1:0] frame_cnt;

  modport slave (
    input  ce_pix, cfg_we, cfg_h_total, cfg_h_fp, cfg_h_bp, cfg_h_sync, cfg_hv_offset,
           cfg_v_total, cfg_v_fp, cfg_v_bp, cfg_v_sync, cfg_interlace, cfg_hs_pol, cfg_vs_pol,
    output cfg_pending, hs, vs, hde, vde, de, field, sof, h_count, v_count, x, y, frame_cnt
  );

  modport master (
    output ce_pix, cfg_we, cfg_h_total, cfg_h_fp, cfg_h_bp, cfg_h_sync, cfg_hv_offset,
           cfg_v_total, cfg_v_fp, cfg_v_bp, cfg_v_sync, cfg_interlace, cfg_hs_pol, cfg_vs_pol,
    input  cfg_pending, hs, vs, hde, vde, de, field, sof, h_count, v_count, x, y, frame_cnt
  );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel-enable driven h/v counters, interlaced
// fields with a half-line VS offset in field 1, per-signal sync polarity,
// and a double-buffered configuration that swaps in only at frame end.
module video_timing_gen #(
  parameter int X_BITS     = 12,
  parameter int Y_BITS     = 12,
  parameter int FRAME_BITS = 8
) (
  input  logic clk,
  input  logic reset,
  video_timing_gen_if.slave vif
);

  typedef struct packed {
    logic [X_BITS-1:0] h_total;
    logic [X_BITS-1:0] h_fp;
    logic [X_BITS-1:0] h_bp;
    logic [X_BITS-1:0] h_sync;
    logic [X_BITS-1:0] hv_offset;
    logic [Y_BITS-1:0] v_total;
    logic [Y_BITS-1:0] v_fp;
    logic [Y_BITS-1:0] v_bp;
    logic [Y_BITS-1:0] v_sync;
    logic              interlace;
    logic              hs_pol;
    logic              vs_pol;
  } cfg_t;

  cfg_t w_cfg_in;
  cfg_t r_act;
  cfg_t r_pend;
  logic r_pending;

  // Internal timing state (the position being described next)
  logic [X_BITS-1:0]     r_h;
  logic [Y_BITS-1:0]     r_v;
  logic                  r_field;
  logic [FRAME_BITS-1:0] r_frame;
  logic                  r_vs_i;

  // Registered outputs
  logic                  r_hs, r_vs, r_hde, r_vde, r_de, r_sof, r_field_out;
  logic [X_BITS-1:0]     r_h_out, r_x;
  logic [Y_BITS-1:0]     r_v_out, r_y;
  logic [FRAME_BITS-1:0] r_frame_out;

  // Combinational next-state and decode
  logic [X_BITS-1:0] w_h_last, w_h_next, w_off, w_off_sum, w_h_start, w_h_end;
  logic [Y_BITS-1:0] w_v_last, w_v_next, w_v_start, w_v_end;
  logic              w_line_end, w_v_wrap, w_frame_end, w_field_next;
  logic              w_hs_i, w_hde, w_vde, w_vs_i_next;

  assign w_cfg_in = '{
    h_total:   vif.cfg_h_total,  h_fp: vif.cfg_h_fp, h_bp: vif.cfg_h_bp,
    h_sync:    vif.cfg_h_sync,   hv_offset: vif.cfg_hv_offset,
    v_total:   vif.cfg_v_total,  v_fp: vif.cfg_v_fp, v_bp: vif.cfg_v_bp,
    v_sync:    vif.cfg_v_sync,   interlace: vif.cfg_interlace,
    hs_pol:    vif.cfg_hs_pol,   vs_pol: vif.cfg_vs_pol
  };

  // Counter advance, field/frame tracking and sync/active-region decode
  always_comb begin
    w_h_last   = r_act.h_total - X_BITS'(1);
    w_line_end = (r_h == w_h_last);
    // Compare with >= so an illegal or shrunken total can never strand the counters
    if (r_act.h_total < X_BITS'(2))  w_h_next = '0;
    else if (r_h >= w_h_last)        w_h_next = '0;
    else                             w_h_next = r_h + X_BITS'(1);

    // Field 1 of an interlaced frame carries one extra line
    w_v_last = (r_act.interlace && r_field) ? r_act.v_total : r_act.v_total - Y_BITS'(1);
    w_v_wrap = w_line_end && (r_v >= w_v_last);
    if (!w_line_end)   w_v_next = r_v;
    else if (w_v_wrap) w_v_next = '0;
    else               w_v_next = r_v + Y_BITS'(1);

    w_frame_end  = w_v_wrap && (r_field == r_act.interlace);
    w_field_next = r_act.interlace ? (w_v_wrap ? ~r_field : r_field) : 1'b0;

    // VS edge column: field 1 is shifted by half a line, folded back into the line
    w_off_sum = r_act.hv_offset + (r_act.h_total >> 1);
    if (r_act.interlace && r_field)
      w_off = (w_off_sum >= r_act.h_total) ? w_off_sum - r_act.h_total : w_off_sum;
    else
      w_off = r_act.hv_offset;

    w_h_start = r_act.h_sync + r_act.h_bp;
    w_h_end   = r_act.h_total - r_act.h_fp - X_BITS'(1);
    w_v_start = r_act.v_sync + r_act.v_bp;
    w_v_end   = r_act.v_total - r_act.v_fp - Y_BITS'(1);
    w_hs_i    = (r_h < r_act.h_sync);
    w_hde     = (r_h >= w_h_start) && (r_h <= w_h_end);
    w_vde     = (r_v >= w_v_start) && (r_v <= w_v_end);

    if (r_v == '0 && r_h == w_off)                 w_vs_i_next = 1'b1;
    else if (r_v == r_act.v_sync && r_h == w_off)  w_vs_i_next = 1'b0;
    else                                           w_vs_i_next = r_vs_i;
  end

  // Timing state and double-buffered configuration
  always_ff @(posedge clk) begin
    if (reset) begin
      r_act     <= w_cfg_in;
      r_pend    <= w_cfg_in;
      r_pending <= 1'b0;
      r_h       <= '0;
      r_v       <= '0;
      r_field   <= 1'b0;
      r_frame   <= '0;
    end else begin
      if (vif.ce_pix) begin
        r_h     <= w_h_next;
        r_v     <= w_v_next;
        r_field <= w_field_next;
        if (w_v_wrap) r_frame <= r_frame + FRAME_BITS'(1);
        if (w_frame_end && r_pending) begin
          r_act     <= r_pend;
          r_pending <= 1'b0;
        end
      end
      // A write landing on the apply cycle stays pending for the next frame
      if (vif.cfg_we) begin
        r_pend    <= w_cfg_in;
        r_pending <= 1'b1;
      end
    end
  end

  // Output registers: each ce publishes the position held before it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hs        <= vif.cfg_hs_pol;
      r_vs        <= vif.cfg_vs_pol;
      r_vs_i      <= 1'b0;
      r_hde       <= 1'b0;
      r_vde       <= 1'b0;
      r_de        <= 1'b0;
      r_sof       <= 1'b0;
      r_field_out <= 1'b0;
      r_h_out     <= '0;
      r_v_out     <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_frame_out <= '0;
    end else begin
      r_sof <= vif.ce_pix && (r_h == '0) && (r_v == '0);
      if (vif.ce_pix) begin
        r_vs_i      <= w_vs_i_next;
        r_hs        <= w_hs_i ^ r_act.hs_pol;
        r_vs        <= w_vs_i_next ^ r_act.vs_pol;
        r_hde       <= w_hde;
        r_vde       <= w_vde;
        r_de        <= w_hde && w_vde;
        r_field_out <= r_field;
        r_h_out     <= r_h;
        r_v_out     <= r_v;
        r_x         <= r_h - w_h_start;
        r_y         <= r_v - w_v_start;
        r_frame_out <= r_frame;
      end
    end
  end

  assign vif.cfg_pending = r_pending;
  assign vif.hs          = r_hs;
  assign vif.vs          = r_vs;
  assign vif.hde         = r_hde;
  assign vif.vde         = r_vde;
  assign vif.de          = r_de;
  assign vif.field       = r_field_out;
  assign vif.sof         = r_sof;
  assign vif.h_count     = r_h_out;
  assign vif.v_count     = r_v_out;
  assign vif.x           = r_x;
  assign vif.y           = r_y;
  assign vif.frame_cnt   = r_frame_out;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen. The driver predicts each clock's
// outputs from a position-in-field model and queues them; the monitor pops
// one entry per clock edge and compares on the following falling edge.
module tb_video_timing_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  video_timing_gen_if #(.X_BITS(12), .Y_BITS(12), .FRAME_BITS(8)) vif ();

  video_timing_gen #(.X_BITS(12), .Y_BITS(12), .FRAME_BITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .vif   (vif)
  );

  typedef struct {
    int ht, hf, hb, hs, off;
    int vt, vf, vb, vs;
    bit il, hp, vp;
  } mcfg_t;

  typedef struct {
    bit pend, hs, vs, hde, vde, de, field, sof;
    int hc, vc, x, y, frame;
  } exp_t;

  exp_t  q[$];
  int    vectors = 0;
  int    miscompares = 0;

  // Reference model state: linear pixel position within the current field
  mcfg_t m_act, m_pend;
  bit    m_pending;
  int    m_p;
  bit    m_field;
  int    m_frame;
  exp_t  m_last;

  function automatic int field_len(mcfg_t c, bit f);
    return c.ht * (c.vt + ((c.il && f) ? 1 : 0));
  endfunction

  function automatic bit frame_end_next();
    return (m_p == field_len(m_act, m_field) - 1) && (m_field == m_act.il);
  endfunction

  function automatic mcfg_t mk(int ht, int hf, int hb, int hs, int off,
                               int vt, int vf, int vb, int vs, bit il, bit hp, bit vp);
    mcfg_t c;
    c.ht = ht; c.hf = hf; c.hb = hb; c.hs = hs; c.off = off;
    c.vt = vt; c.vf = vf; c.vb = vb; c.vs = vs; c.il = il; c.hp = hp; c.vp = vp;
    return c;
  endfunction

  function automatic mcfg_t rand_cfg();
    mcfg_t c;
    c.hs = $urandom_range(1, 3); c.hb = $urandom_range(0, 3); c.hf = $urandom_range(0, 3);
    c.ht = c.hs + c.hb + c.hf + 1 + $urandom_range(0, 8);
    c.off = $urandom_range(0, c.ht - 1);
    c.vs = $urandom_range(1, 2); c.vb = $urandom_range(0, 2); c.vf = $urandom_range(0, 2);
    c.vt = c.vs + c.vb + c.vf + 1 + $urandom_range(0, 3);
    c.il = 1'($urandom_range(0, 1));
    c.hp = 1'($urandom_range(0, 1));
    c.vp = 1'($urandom_range(0, 1));
    return c;
  endfunction

  // Expected outputs for one pixel, straight from the raster rules
  function automatic exp_t pixel(mcfg_t c, int p, bit f, int frame, bit pend);
    exp_t e;
    int h, v, off, vs_i;
    h = p % c.ht;
    v = p / c.ht;
    off = c.off;
    if (c.il && f) begin
      off = c.off + c.ht / 2;
      if (off >= c.ht) off -= c.ht;
    end
    // VS is high from (line 0, off) up to but excluding (line vs, off)
    vs_i = (p >= off) && (p < c.vs * c.ht + off);
    e.pend  = pend;
    e.hs    = (h < c.hs) ^ c.hp;
    e.vs    = 1'(vs_i) ^ c.vp;
    e.hde   = (h >= c.hs + c.hb) && (h <= c.ht - c.hf - 1);
    e.vde   = (v >= c.vs + c.vb) && (v <= c.vt - c.vf - 1);
    e.de    = e.hde && e.vde;
    e.field = f;
    e.sof   = (p == 0);
    e.hc    = h;
    e.vc    = v;
    e.x     = (h - c.hs - c.hb) & 32'hFFF;
    e.y     = (v - c.vs - c.vb) & 32'hFFF;
    e.frame = frame;
    return e;
  endfunction

  // Drive one clock of stimulus, predict its result, then advance a clock
  task automatic step(bit rst, bit ce, bit we, mcfg_t c);
    exp_t e;
    reset             = rst;
    vif.ce_pix        = ce;
    vif.cfg_we        = we;
    vif.cfg_h_total   = 12'(c.ht);
    vif.cfg_h_fp      = 12'(c.hf);
    vif.cfg_h_bp      = 12'(c.hb);
    vif.cfg_h_sync    = 12'(c.hs);
    vif.cfg_hv_offset = 12'(c.off);
    vif.cfg_v_total   = 12'(c.vt);
    vif.cfg_v_fp      = 12'(c.vf);
    vif.cfg_v_bp      = 12'(c.vb);
    vif.cfg_v_sync    = 12'(c.vs);
    vif.cfg_interlace = c.il;
    vif.cfg_hs_pol    = c.hp;
    vif.cfg_vs_pol    = c.vp;
    if (rst) begin
      m_act = c; m_pend = c; m_pending = 0; m_p = 0; m_field = 0; m_frame = 0;
      e = '{pend: 0, hs: c.hp, vs: c.vp, hde: 0, vde: 0, de: 0, field: 0, sof: 0,
            hc: 0, vc: 0, x: 0, y: 0, frame: 0};
    end else begin
      e = m_last;
      e.sof = 0;
      if (ce) begin
        e = pixel(m_act, m_p, m_field, m_frame, 0);
        m_p++;
        if (m_p == field_len(m_act, m_field)) begin
          bit fe;
          fe = (m_field == m_act.il);
          m_p = 0;
          m_frame = (m_frame + 1) % 256;
          m_field = m_act.il ? !m_field : 1'b0;
          if (fe && m_pending) begin
            m_act = m_pend;
            m_pending = 0;
          end
        end
      end
      if (we) begin
        m_pend = c;
        m_pending = 1;
        $display("cfg write t=%0t ht=%0d vt=%0d il=%0d pol=%0d%0d", $time, c.ht, c.vt, c.il, c.hp, c.vp);
      end
      e.pend = m_pending;
    end
    m_last = e;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(mcfg_t c, int n);
    $display("reset t=%0t ht=%0d vt=%0d il=%0d pol=%0d%0d", $time, c.ht, c.vt, c.il, c.hp, c.vp);
    repeat (n) step(1, 0, 0, c);
  endtask

  task automatic chk(string name, int act, int exp, inout bit bad);
    if (act != exp) begin
      $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp);
      bad = 1;
    end
  endtask

  // Monitor: one queued expectation per clock edge, checked mid-cycle
  initial begin
    forever begin
      int n;
      exp_t e;
      bit bad;
      @(posedge clk);
      n = q.size();
      @(negedge clk);
      if (n > 0) begin
        e = q.pop_front();
        bad = 0;
        chk("cfg_pending", int'(vif.cfg_pending), int'(e.pend), bad);
        chk("hs", int'(vif.hs), int'(e.hs), bad);
        chk("vs", int'(vif.vs), int'(e.vs), bad);
        chk("hde", int'(vif.hde), int'(e.hde), bad);
        chk("vde", int'(vif.vde), int'(e.vde), bad);
        chk("de", int'(vif.de), int'(e.de), bad);
        chk("field", int'(vif.field), int'(e.field), bad);
        chk("sof", int'(vif.sof), int'(e.sof), bad);
        chk("h_count", int'(vif.h_count), e.hc, bad);
        chk("v_count", int'(vif.v_count), e.vc, bad);
        chk("x", int'(vif.x), e.x, bad);
        chk("y", int'(vif.y), e.y, bad);
        chk("frame_cnt", int'(vif.frame_cnt), e.frame, bad);
        vectors++;
        if (bad) miscompares++;
      end
    end
  end

  initial begin
    mcfg_t a, b, c12, d, pa, r;
    int guard;
    a   = mk(10, 2, 2, 2, 0, 6, 1, 1, 1, 0, 0, 0);
    b   = mk(10, 2, 2, 2, 0, 6, 1, 1, 1, 1, 0, 0);
    c12 = mk(12, 2, 2, 2, 0, 6, 1, 1, 1, 0, 0, 0);
    d   = mk(14, 3, 2, 2, 3, 7, 1, 1, 2, 0, 1, 0);
    pa  = mk(10, 2, 2, 2, 0, 6, 1, 1, 1, 0, 1, 1);

    // Progressive baseline with continuous pixel enable
    do_reset(a, 3);
    for (int i = 0; i < 150; i++) step(0, 1, 0, a);

    // Pixel enable one clock in three
    for (int i = 0; i < 210; i++) step(0, (i % 3) == 0, 0, a);

    // Interlaced fields, 60 then 70 pixels
    do_reset(b, 2);
    for (int i = 0; i < 300; i++) step(0, 1, 0, b);

    // Mid-frame write of a 12-wide line, then a write on the frame-end cycle
    do_reset(a, 2);
    for (int i = 0; i < 25; i++) step(0, 1, 0, a);
    step(0, 1, 1, c12);
    guard = 0;
    while (m_pending && guard < 200) begin step(0, 1, 0, a); guard++; end
    for (int i = 0; i < 30; i++) step(0, 1, 0, a);
    step(0, 1, 1, d);
    guard = 0;
    while (!frame_end_next() && guard < 200) begin step(0, 1, 0, a); guard++; end
    step(0, 1, 1, a);
    for (int i = 0; i < 200; i++) step(0, 1, 0, a);

    // Inverted sync polarities, including the reset level
    do_reset(pa, 3);
    for (int i = 0; i < 150; i++) step(0, 1, 0, pa);

    // Reset at h=5, v=3 with a pending configuration
    do_reset(a, 2);
    for (int i = 0; i < 30; i++) step(0, 1, 0, a);
    step(0, 1, 1, c12);
    guard = 0;
    while (m_p != 35 && guard < 200) begin step(0, 1, 0, a); guard++; end
    do_reset(a, 1);
    for (int i = 0; i < 100; i++) step(0, 1, 0, a);

    // Randomised configurations, enables and writes
    for (int round = 0; round < 8; round++) begin
      r = rand_cfg();
      if (round % 3 == 0) do_reset(r, 1 + $urandom_range(0, 2));
      for (int i = 0; i < 400; i++) begin
        bit ce, we;
        ce = ($urandom_range(0, 99) < 70);
        we = ($urandom_range(0, 199) == 0);
        if (we) r = rand_cfg();
        step(0, ce, we, r);
      end
    end

    guard = 0;
    while (q.size() > 0 && guard < 20) begin @(negedge clk); guard++; end
    #2;
    if (q.size() > 0) begin
      $display("FAIL drain t=%0t got=%0d pending expectations expected=0", $time, q.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
